// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the divided-clock generator.
// The config struct bundles one request on the config port.
package clk_div_gen_pkg;

  localparam int CHAN_W    = 2;
  localparam int CFG_DIV_W = 8;

  typedef struct packed {
    logic [CHAN_W-1:0]    chan;
    logic [CFG_DIV_W-1:0] div;
    logic                 en;
  } cfg_t;

  // The falling toggle of a running channel: the only safe point to swap ratio/enable.
  function automatic logic is_boundary(input int cnt, input int div, input logic out);
    return (cnt == div) && out;
  endfunction

endpackage

// File: rtl/clk_div_gen_chan.sv
// One divided-clock channel: half-period counter, output toggle flop,
// and a single-entry pending config that commits only at a period boundary.
module clk_div_chan
  import clk_div_gen_pkg::*;
#(
  parameter int   DIV_W   = 8,
  parameter int   RST_DIV = 0,
  parameter logic RST_EN  = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             active_o
);

  logic [DIV_W-1:0] div_cur_q,  div_cur_d;
  logic             en_cur_q,   en_cur_d;
  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic             out_q,      out_d;
  logic             pend_q,     pend_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             en_pend_q,  en_pend_d;
  logic             commit;

  always_comb begin
    div_cur_d  = div_cur_q;
    en_cur_d   = en_cur_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    pend_d     = pend_q;
    div_pend_d = div_pend_q;
    en_pend_d  = en_pend_q;

    // A stopped channel has no phase to protect, so it commits at once.
    commit = pend_q &&
             (!en_cur_q || is_boundary(int'(cnt_q), int'(div_cur_q), out_q));

    if (commit) begin
      div_cur_d = div_pend_q;
      en_cur_d  = en_pend_q;
      pend_d    = 1'b0;
      out_d     = 1'b0;
      cnt_d     = '0;
    end else if (en_cur_q) begin
      if (cnt_q == div_cur_q) begin
        out_d = ~out_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      out_d = 1'b0;
      cnt_d = '0;
    end

    // The top only accepts while pend_q is low, so this never overlaps a commit.
    if (acc_i && !pend_q) begin
      pend_d     = 1'b1;
      div_pend_d = div_i;
      en_pend_d  = en_i;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cur_q  <= DIV_W'(RST_DIV);
      en_cur_q   <= RST_EN;
      cnt_q      <= '0;
      out_q      <= 1'b0;
      pend_q     <= 1'b0;
      div_pend_q <= '0;
      en_pend_q  <= 1'b0;
    end else begin
      div_cur_q  <= div_cur_d;
      en_cur_q   <= en_cur_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      div_pend_q <= div_pend_d;
      en_pend_q  <= en_pend_d;
    end
  end

  assign pend_o   = pend_q;
  assign clk_o    = out_q;
  assign active_o = en_cur_q;

endmodule

// File: rtl/clk_div_gen.sv
// Candidate-clock source for the glitch-free selector: NUM_CLK divided 50%-duty
// clocks, each reprogrammed through one shared valid/ready config port.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int                 NUM_CLK = 3,
  parameter int                 DIV_W   = CFG_DIV_W,
  parameter int                 RST_DIV = 0,
  parameter logic [NUM_CLK-1:0] RST_EN  = NUM_CLK'(1)
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CHAN_W-1:0]  cfg_chan,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               cfg_en,
  output logic [NUM_CLK-1:0] clk_out,
  output logic [NUM_CLK-1:0] clk_active
);

  localparam int NUM_SLOT = 2 ** CHAN_W;

  cfg_t                cfg_s;
  logic                cfg_fire;
  logic [NUM_CLK-1:0]  pend;
  logic [NUM_CLK-1:0]  acc;
  logic [NUM_SLOT-1:0] pend_all;

  always_comb begin
    cfg_s      = '0;
    cfg_s.chan = cfg_chan;
    cfg_s.div  = CFG_DIV_W'(cfg_div);
    cfg_s.en   = cfg_en;
  end

  // Unimplemented channel indices are always ready so a stray request drains.
  always_comb begin
    pend_all              = '0;
    pend_all[NUM_CLK-1:0] = pend;
    if ({1'b0, cfg_s.chan} < (CHAN_W + 1)'(NUM_CLK)) begin
      cfg_ready = ~pend_all[cfg_s.chan];
    end else begin
      cfg_ready = 1'b1;
    end
  end

  assign cfg_fire = cfg_valid && cfg_ready;

  for (genvar gi = 0; gi < NUM_CLK; gi++) begin : g_chan
    assign acc[gi] = cfg_fire && (cfg_s.chan == CHAN_W'(gi));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV),
      .RST_EN  (RST_EN[gi])
    ) u_chan (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .acc_i    (acc[gi]),
      .div_i    (cfg_s.div[DIV_W-1:0]),
      .en_i     (cfg_s.en),
      .pend_o   (pend[gi]),
      .clk_o    (clk_out[gi]),
      .active_o (clk_active[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a phase-countdown reference predicts each
// cycle's clk_out/clk_active, queued at drive time and compared after the edge.
module tb_clk_div_gen;

  localparam int NCH = 3;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_chan;
  logic [7:0]     cfg_div;
  logic           cfg_en;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] clk_active;

  clk_div_gen #(
    .NUM_CLK (NCH),
    .DIV_W   (8),
    .RST_DIV (0),
    .RST_EN  (3'b001)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .clk_out    (clk_out),
    .clk_active (clk_active)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NCH-1:0] out;
    logic [NCH-1:0] act;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Reference state: level plus edges remaining before the next toggle.
  int m_div[NCH], m_left[NCH], m_divp[NCH];
  bit m_en[NCH], m_lvl[NCH], m_pend[NCH], m_enp[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]  = 0;
      m_en[i]   = (i == 0);
      m_lvl[i]  = 1'b0;
      m_left[i] = 1;
      m_pend[i] = 1'b0;
      m_divp[i] = 0;
      m_enp[i]  = 1'b0;
    end
  endtask

  function automatic bit exp_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_step(input bit v, input int ch, input int dv, input bit e,
                            output bit accepted);
    accepted = v && exp_ready(ch);
    for (int i = 0; i < NCH; i++) begin
      bit acc, commit;
      acc    = v && (ch == i) && !m_pend[i];
      commit = m_pend[i] && (!m_en[i] || (m_lvl[i] && m_left[i] == 1));
      if (commit) begin
        m_div[i]  = m_divp[i];
        m_en[i]   = m_enp[i];
        m_pend[i] = 1'b0;
        m_lvl[i]  = 1'b0;
        m_left[i] = m_divp[i] + 1;
      end else if (m_en[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_lvl[i]  = ~m_lvl[i];
          m_left[i] = m_div[i] + 1;
        end
      end else begin
        m_lvl[i]  = 1'b0;
        m_left[i] = m_div[i] + 1;
      end
      if (acc) begin
        m_pend[i] = 1'b1;
        m_divp[i] = dv;
        m_enp[i]  = e;
      end
    end
  endtask

  task automatic step(input bit v, input int ch, input int dv, input bit e,
                      output bit accepted);
    exp_t x;
    @(negedge clk_in);
    cfg_valid = v;
    cfg_chan  = 2'(ch);
    cfg_div   = 8'(dv);
    cfg_en    = e;
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready(ch)});
    model_step(v, ch, dv, e, accepted);
    if (accepted) $display("cfg  cyc=%0d ch=%0d div=%0d en=%0d", cyc, ch, dv, e);
    for (int i = 0; i < NCH; i++) begin
      x.out[i] = m_lvl[i];
      x.act[i] = m_en[i];
    end
    sb.push_back(x);
    @(posedge clk_in);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk("clk_out", {29'd0, clk_out}, {29'd0, x.out});
      chk("clk_active", {29'd0, clk_active}, {29'd0, x.act});
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, a);
  endtask

  // Advance until channel ch is idle-pending and inside its high phase with room left.
  task automatic wait_high(input int ch, input string tag);
    int k;
    k = 0;
    while (!(m_pend[ch] == 1'b0 && m_lvl[ch] && m_left[ch] > 1) && k < 40) begin
      idle(1);
      k++;
    end
    if (k >= 40) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    #2;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    #1;
    chk("rst_clk_out", {29'd0, clk_out}, 32'd0);
    chk("rst_clk_active", {29'd0, clk_active}, 32'd1);
    model_reset();
    sb.delete();
    @(posedge clk_in);
    #1;
    chk("rst_hold_out", {29'd0, clk_out}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    int k;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_en    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_clk_out", {29'd0, clk_out}, 32'd0);
    chk("reset_clk_active", {29'd0, clk_active}, 32'd1);
    rst_n = 1'b1;

    // Defaults: channel 0 at clk_in/2, others idle.
    idle(6);

    // Stopped channel 1 gets div=2: commits next edge, period 6.
    step(1'b1, 1, 2, 1'b1, a);
    chk("ch1_accept", {31'd0, a}, 32'd1);
    idle(14);

    // Channel 0 to div=3, then shorten to div=1 in the middle of a high phase.
    step(1'b1, 0, 3, 1'b1, a);
    idle(12);
    wait_high(0, "wait_ch0_high");
    step(1'b1, 0, 1, 1'b1, a);
    idle(16);

    // Pending ch0 stalls a second config; ch2 is accepted meanwhile.
    step(1'b1, 0, 3, 1'b1, a);
    k = 0;
    a = 1'b0;
    while (!a && k < 30) begin
      if (k == 1) begin
        step(1'b1, 2, 1, 1'b1, a);
        chk("ch2_accept", {31'd0, a}, 32'd1);
        a = 1'b0;
      end else begin
        step(1'b1, 0, 2, 1'b1, a);
      end
      k++;
    end
    chk("ch0_second_accept", {31'd0, a}, 32'd1);
    idle(14);

    // Disable channel 0 during its high phase.
    wait_high(0, "wait_ch0_high2");
    step(1'b1, 0, 2, 1'b0, a);
    idle(20);

    // Out-of-range channel index drains with no effect.
    step(1'b1, 3, 5, 1'b1, a);
    chk("chan3_accept", {31'd0, a}, 32'd1);
    idle(4);

    // Reset while channel 1 has a config pending.
    step(1'b1, 1, 7, 1'b1, a);
    idle(1);
    async_reset();
    idle(6);
    step(1'b1, 1, 0, 1'b1, a);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
